// File: rtl/b1_smpl_queue_if.sv
// Sample-queue handshake bundle: the producer writes audio samples and the FIR side
// consumes the replayed stream along with its status flags.
`timescale 1ns/1ps
interface b1_smpl_queue_if #(
  parameter int DW = 16
);
  logic                 wrt_smpl;
  logic signed [DW-1:0] new_smpl;
  logic signed [DW-1:0] smpl_out;
  logic                 sequencing;
  logic                 full;
  logic                 overrun;

  modport master (
    output wrt_smpl, new_smpl,
    input  smpl_out, sequencing, full, overrun
  );

  modport slave (
    input  wrt_smpl, new_smpl,
    output smpl_out, sequencing, full, overrun
  );
endinterface

// File: rtl/b1_smpl_queue.sv
// Circular sample buffer: stores the last DEPTH audio samples and, after each
// accepted write once full, replays them oldest-to-newest to the FIR engine.
`timescale 1ns/1ps
module b1_smpl_queue #(
  parameter int DEPTH = 1021,
  parameter int DW    = 16
) (
  input logic            clk,
  input logic            rst_n,
  b1_smpl_queue_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c);
    return (c == DEPTH_CNT) ? c : c + CW'(1);
  endfunction

  logic signed [DW-1:0] mem [0:DEPTH-1];

  logic [1:0]           rst_sync_d,  rst_sync_q;
  logic [1:0]           state_d,     state_q;
  logic [AW-1:0]        wptr_d,      wptr_q;
  logic [AW-1:0]        rptr_d,      rptr_q;
  logic [CW-1:0]        cnt_d,       cnt_q;
  logic [CW-1:0]        rcnt_d,      rcnt_q;
  logic signed [DW-1:0] smpl_out_d,  smpl_out_q;
  logic                 seq_d,       seq_q;
  logic                 full_d,      full_q;
  logic                 ovr_d,       ovr_q;
  logic                 mem_we;
  logic                 run;

  // Reset release is retimed so the first edges after deassertion do nothing
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign run        = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    rcnt_d     = rcnt_q;
    smpl_out_d = smpl_out_q;
    seq_d      = seq_q;
    full_d     = full_q;
    ovr_d      = ovr_q;
    mem_we     = 1'b0;
    if (run) begin
      case (state_q)
        S_IDLE: begin
          if (bus.wrt_smpl) begin
            mem_we = 1'b1;
            wptr_d = ptr_inc(wptr_q);
            cnt_d  = cnt_sat_inc(cnt_q);
            // Once full, the slot just past the newest sample is the oldest one
            if (cnt_d == DEPTH_CNT) begin
              full_d  = 1'b1;
              state_d = S_PRIME;
              rptr_d  = wptr_d;
            end
          end
        end
        S_PRIME: begin
          if (bus.wrt_smpl) ovr_d = 1'b1;
          smpl_out_d = mem[rptr_q];
          seq_d      = 1'b1;
          rptr_d     = ptr_inc(rptr_q);
          rcnt_d     = CW'(1);
          state_d    = S_READ;
        end
        S_READ: begin
          if (bus.wrt_smpl) ovr_d = 1'b1;
          if (rcnt_q == DEPTH_CNT) begin
            seq_d   = 1'b0;
            rcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            smpl_out_d = mem[rptr_q];
            rptr_d     = ptr_inc(rptr_q);
            rcnt_d     = rcnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q] <= bus.new_smpl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      smpl_out_q <= '0;
      seq_q      <= 1'b0;
      full_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      smpl_out_q <= smpl_out_d;
      seq_q      <= seq_d;
      full_q     <= full_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.smpl_out   = smpl_out_q;
  assign bus.sequencing = seq_q;
  assign bus.full       = full_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_b1_smpl_queue.sv
// Directed bench for b1_smpl_queue at DEPTH=8 and DEPTH=1021 with a queue model
// of the last DEPTH accepted samples.
`timescale 1ns/1ps
module tb_b1_smpl_queue;
  logic clk = 1'b0;
  logic rst_n8;
  logic rst_nk;
  always #10 clk = ~clk;

  b1_smpl_queue_if #(.DW(16)) if8 ();
  b1_smpl_queue_if #(.DW(16)) ifk ();

  b1_smpl_queue #(.DEPTH(8), .DW(16)) dut8 (
    .clk   (clk),
    .rst_n (rst_n8),
    .bus   (if8)
  );

  b1_smpl_queue #(.DEPTH(1021), .DW(16)) dutk (
    .clk   (clk),
    .rst_n (rst_nk),
    .bus   (ifk)
  );

  int checks = 0;
  int errors = 0;
  int seq_cyc8 = 0;
  int seq_cyck = 0;
  logic signed [15:0] mdl8 [$];
  logic signed [15:0] mdlk [$];
  logic signed [15:0] pass_first;
  logic signed [15:0] pass_second;
  logic signed [15:0] prev_second;

  always @(posedge clk) begin
    if (if8.sequencing) seq_cyc8 <= seq_cyc8 + 1;
    if (ifk.sequencing) seq_cyck <= seq_cyck + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_seq(input int sel);
    return (sel == 0) ? if8.sequencing : ifk.sequencing;
  endfunction

  function automatic logic signed [15:0] get_out(input int sel);
    return (sel == 0) ? if8.smpl_out : ifk.smpl_out;
  endfunction

  task automatic write_smpl(input int sel, input logic signed [15:0] v);
    @(negedge clk);
    if (sel == 0) begin if8.new_smpl = v; if8.wrt_smpl = 1'b1; end
    else          begin ifk.new_smpl = v; ifk.wrt_smpl = 1'b1; end
    @(negedge clk);
    if8.wrt_smpl = 1'b0;
    ifk.wrt_smpl = 1'b0;
  endtask

  task automatic accept(input int sel, input logic signed [15:0] v, input int depth);
    write_smpl(sel, v);
    if (sel == 0) begin
      mdl8.push_back(v);
      if (mdl8.size() > depth) void'(mdl8.pop_front());
    end else begin
      mdlk.push_back(v);
      if (mdlk.size() > depth) void'(mdlk.pop_front());
    end
  endtask

  // Called at the negedge right after the triggering write edge.
  task automatic check_pass(input int sel, input int depth, input int inj_at, input string tag);
    logic signed [15:0] e [$];
    if (sel == 0) e = mdl8; else e = mdlk;
    chk({tag, "_lat"}, 32'(get_seq(sel)), 32'd0);
    for (int k = 0; k < depth; k++) begin
      @(negedge clk);
      if8.wrt_smpl = 1'b0;
      ifk.wrt_smpl = 1'b0;
      chk($sformatf("%s_seq%0d", tag, k), 32'(get_seq(sel)), 32'd1);
      chk($sformatf("%s_smp%0d", tag, k), 32'(get_out(sel)), 32'(e[k]));
      if (k == 0) pass_first  = get_out(sel);
      if (k == 1) pass_second = get_out(sel);
      if (k == inj_at) begin
        if (sel == 0) begin if8.new_smpl = 16'sh8000; if8.wrt_smpl = 1'b1; end
        else          begin ifk.new_smpl = 16'sh8000; ifk.wrt_smpl = 1'b1; end
      end
    end
    @(negedge clk);
    if8.wrt_smpl = 1'b0;
    ifk.wrt_smpl = 1'b0;
    chk({tag, "_end"}, 32'(get_seq(sel)), 32'd0);
    chk({tag, "_hold"}, 32'(get_out(sel)), 32'(e[depth-1]));
  endtask

  function automatic logic signed [15:0] kval(input int i);
    if (i == 0) return 16'sh8000;
    if (i == 1) return 16'sh7FFF;
    return 16'(i * 97 + 12345);
  endfunction

  initial begin
    int snap;
    rst_n8 = 1'b0;
    rst_nk = 1'b0;
    if8.wrt_smpl = 1'b0; if8.new_smpl = '0;
    ifk.wrt_smpl = 1'b0; ifk.new_smpl = '0;
    repeat (3) @(negedge clk);
    chk("rst_seq",  32'(if8.sequencing), 32'd0);
    chk("rst_out",  32'(if8.smpl_out),   32'd0);
    chk("rst_full", 32'(if8.full),       32'd0);
    chk("rst_ovr",  32'(if8.overrun),    32'd0);
    rst_n8 = 1'b1;
    rst_nk = 1'b1;
    repeat (4) @(negedge clk);

    // Fill DEPTH=8
    for (int i = 1; i <= 7; i++) begin
      accept(0, 16'(i), 8);
      repeat (19) @(negedge clk);
    end
    chk("fill_noseq", 32'(seq_cyc8), 32'd0);
    chk("fill_full0", 32'(if8.full), 32'd0);
    accept(0, 16'sd8, 8);
    chk("fill_full1", 32'(if8.full), 32'd1);
    check_pass(0, 8, -1, "p8_fill");
    chk("fill_seqcnt", 32'(seq_cyc8), 32'd8);

    // Steady state
    repeat (3) @(negedge clk);
    accept(0, 16'sd9, 8);
    check_pass(0, 8, -1, "p8_w9");
    accept(0, 16'sd10, 8);
    check_pass(0, 8, -1, "p8_w10");
    chk("steady_ovr0", 32'(if8.overrun), 32'd0);

    // Overrun: dropped 0x8000 mid-pass, then signed extremes replayed
    accept(0, 16'sh7FFF, 8);
    check_pass(0, 8, 3, "p8_ovr");
    chk("ovr_set", 32'(if8.overrun), 32'd1);
    accept(0, 16'sh8000, 8);
    check_pass(0, 8, -1, "p8_ext");
    chk("ovr_sticky", 32'(if8.overrun), 32'd1);
    rst_n8 = 1'b0;
    #1;
    chk("rst8_ovr",  32'(if8.overrun),    32'd0);
    chk("rst8_full", 32'(if8.full),       32'd0);
    chk("rst8_out",  32'(if8.smpl_out),   32'd0);

    // DEPTH=1021: fill, then reset at pass cycle 500
    for (int i = 0; i < 1021; i++) accept(1, kval(i), 1021);
    chk("k_full1", 32'(ifk.full), 32'd1);
    chk("k_lat", 32'(ifk.sequencing), 32'd0);
    repeat (500) @(negedge clk);
    chk("k_mid_seq", 32'(ifk.sequencing), 32'd1);
    chk("k_mid_smp", 32'(ifk.smpl_out), 32'(mdlk[499]));
    rst_nk = 1'b0;
    #1;
    chk("k_rst_seq",  32'(ifk.sequencing), 32'd0);
    chk("k_rst_out",  32'(ifk.smpl_out),   32'd0);
    chk("k_rst_full", 32'(ifk.full),       32'd0);
    mdlk.delete();
    repeat (3) @(negedge clk);
    rst_nk = 1'b1;
    repeat (4) @(negedge clk);
    snap = seq_cyck;
    for (int i = 0; i < 1020; i++) accept(1, kval(i + 3), 1021);
    chk("k_refill_noseq", 32'(seq_cyck - snap), 32'd0);
    chk("k_refill_full0", 32'(ifk.full), 32'd0);
    accept(1, kval(2000), 1021);
    chk("k_refill_full1", 32'(ifk.full), 32'd1);
    check_pass(1, 1021, -1, "pk_refill");
    prev_second = pass_second;

    // 48 kHz strobes on 50 MHz clock: 1042 clocks apart
    for (int p = 0; p < 3; p++) begin
      repeat (18) @(negedge clk);
      snap = seq_cyck;
      accept(1, kval(3000 + p), 1021);
      check_pass(1, 1021, -1, $sformatf("pk_wrap%0d", p));
      chk($sformatf("pk_len%0d", p), 32'(seq_cyck - snap), 32'd1021);
      chk($sformatf("pk_shift%0d", p), 32'(pass_first), 32'(prev_second));
      prev_second = pass_second;
    end
    chk("k_ovr0", 32'(ifk.overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
